// File: rtl/sample_fifo_pkg.sv
// Shared buffer definitions: default sample width/depth and the log2 helper
// used to size pointers and level counters.
package buffer_defs;

  localparam int DEF_DATA_W = 9;
  localparam int DEF_DEPTH  = 16;

  // Ceiling log2; for the power-of-two depths used here it is exact.
  function automatic int log2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/sample_fifo_if.sv
// Producer/consumer handshake bundle for sample_fifo; master drives requests,
// slave (the FIFO) returns acks, head data and status.
interface sample_fifo_if
  import buffer_defs::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
);
  localparam int LVL_W = log2(DEPTH) + 1;

  logic              flush;
  logic [DATA_W-1:0] data_in;
  logic              data_in_valid;
  logic              data_in_ack;
  logic [DATA_W-1:0] data_out;
  logic              data_out_valid;
  logic              data_out_read;
  logic [LVL_W-1:0]  level;
  logic              almost_full;
  logic              overflow;
  logic              underflow;

  modport master (
    output flush, data_in, data_in_valid, data_out_read,
    input  data_in_ack, data_out, data_out_valid, level, almost_full,
           overflow, underflow
  );

  modport slave (
    input  flush, data_in, data_in_valid, data_out_read,
    output data_in_ack, data_out, data_out_valid, level, almost_full,
           overflow, underflow
  );

endinterface

// File: rtl/sample_fifo_mem.sv
// DEPTH x DATA_W register array with one synchronous write port and one
// asynchronous read port; contents are intentionally never reset.
module sample_fifo_mem #(
  parameter int DATA_W = 9,
  parameter int DEPTH  = 16,
  parameter int PTR_W  = 4
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [PTR_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [PTR_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sample_fifo.sv
// First-word fall-through sample FIFO: pointer, level and sticky error flag
// control around a register-array storage block.
module sample_fifo
  import buffer_defs::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int DEPTH    = DEF_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input logic         clk,
  input logic         rst,
  sample_fifo_if.slave bus
);

  localparam int PTR_W = log2(DEPTH);
  localparam int LVL_W = log2(DEPTH) + 1;

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic             overflow_q;
  logic             underflow_q;
  logic             full;
  logic             empty;
  logic             push;
  logic             pop;

  assign full  = (level_q == LVL_W'(DEPTH));
  assign empty = (level_q == '0);

  // Reset gates the ack so a producer holding valid during reset sees no acceptance.
  assign push = bus.data_in_valid & ~full & ~bus.flush & rst;
  assign pop  = bus.data_out_read & ~empty & ~bus.flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.flush) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      level_q     <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
      if (bus.data_in_valid & full)  overflow_q  <= 1'b1;
      if (bus.data_out_read & empty) underflow_q <= 1'b1;
    end
  end

  sample_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .clk     (clk),
    .wr_en   (push),
    .wr_addr (wr_ptr),
    .wr_data (bus.data_in),
    .rd_addr (rd_ptr),
    .rd_data (bus.data_out)
  );

  assign bus.data_in_ack    = push;
  assign bus.data_out_valid = ~empty;
  assign bus.level          = level_q;
  assign bus.almost_full    = (level_q >= LVL_W'(AF_LEVEL));
  assign bus.overflow       = overflow_q;
  assign bus.underflow      = underflow_q;

endmodule

// File: tb/tb_sample_fifo.sv
// Directed, table-driven bench for sample_fifo at DATA_W=9, DEPTH=4, AF_LEVEL=3,
// with hand-written sequences for reset behaviour.
module tb_sample_fifo;

  localparam int DATA_W   = 9;
  localparam int DEPTH    = 4;
  localparam int AF_LEVEL = 3;

  typedef struct {
    logic       flush;
    logic       wv;
    logic [8:0] wd;
    logic       rd;
    logic       ack;
    logic [2:0] lvl;
    logic       vld;
    logic [8:0] dout;
    logic       af;
    logic       ov;
    logic       uf;
  } vec_t;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;
  vec_t vecs [23];

  sample_fifo_if #(.DATA_W(DATA_W), .DEPTH(DEPTH)) bus ();

  sample_fifo #(
    .DATA_W   (DATA_W),
    .DEPTH    (DEPTH),
    .AF_LEVEL (AF_LEVEL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t mk(
    input logic flush, input logic wv, input logic [8:0] wd, input logic rd,
    input logic ack, input logic [2:0] lvl, input logic vld, input logic [8:0] dout,
    input logic af, input logic ov, input logic uf);
    vec_t v;
    v.flush = flush; v.wv = wv; v.wd = wd; v.rd = rd;
    v.ack = ack; v.lvl = lvl; v.vld = vld; v.dout = dout;
    v.af = af; v.ov = ov; v.uf = uf;
    return v;
  endfunction

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Drive one cycle of inputs, check the combinational ack, then the registered state after the edge.
  task automatic apply_stimulus(input vec_t v, input int idx);
    @(negedge clk);
    bus.flush         = v.flush;
    bus.data_in_valid = v.wv;
    bus.data_in       = v.wd;
    bus.data_out_read = v.rd;
    #1;
    check_output($sformatf("ack[%0d]", idx), 32'(bus.data_in_ack), 32'(v.ack));
    @(posedge clk);
    #1;
    check_output($sformatf("level[%0d]", idx), 32'(bus.level), 32'(v.lvl));
    check_output($sformatf("valid[%0d]", idx), 32'(bus.data_out_valid), 32'(v.vld));
    if (v.vld)
      check_output($sformatf("dout[%0d]", idx), 32'(bus.data_out), 32'(v.dout));
    check_output($sformatf("afull[%0d]", idx), 32'(bus.almost_full), 32'(v.af));
    check_output($sformatf("ovf[%0d]", idx), 32'(bus.overflow), 32'(v.ov));
    check_output($sformatf("udf[%0d]", idx), 32'(bus.underflow), 32'(v.uf));
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;

    //               fl wv wd      rd  ack lvl vld dout    af ov uf
    vecs[0]  = mk(0, 1, 9'h1FF, 0,  1, 1, 1, 9'h1FF, 0, 0, 0);
    vecs[1]  = mk(0, 1, 9'h00F, 0,  1, 2, 1, 9'h1FF, 0, 0, 0);
    vecs[2]  = mk(0, 1, 9'h003, 0,  1, 3, 1, 9'h1FF, 1, 0, 0);
    vecs[3]  = mk(0, 1, 9'h0AA, 0,  1, 4, 1, 9'h1FF, 1, 0, 0);
    vecs[4]  = mk(0, 1, 9'h183, 1,  0, 3, 1, 9'h00F, 1, 1, 0);
    vecs[5]  = mk(0, 1, 9'h183, 0,  1, 4, 1, 9'h00F, 1, 1, 0);
    vecs[6]  = mk(0, 0, 9'h000, 1,  0, 3, 1, 9'h003, 1, 1, 0);
    vecs[7]  = mk(0, 0, 9'h000, 1,  0, 2, 1, 9'h0AA, 0, 1, 0);
    vecs[8]  = mk(0, 0, 9'h000, 1,  0, 1, 1, 9'h183, 0, 1, 0);
    vecs[9]  = mk(0, 0, 9'h000, 1,  0, 0, 0, 9'h000, 0, 1, 0);
    vecs[10] = mk(0, 0, 9'h000, 1,  0, 0, 0, 9'h000, 0, 1, 1);
    vecs[11] = mk(0, 1, 9'h055, 1,  1, 1, 1, 9'h055, 0, 1, 1);
    vecs[12] = mk(0, 1, 9'h0BB, 0,  1, 2, 1, 9'h055, 0, 1, 1);
    vecs[13] = mk(0, 1, 9'h001, 1,  1, 2, 1, 9'h0BB, 0, 1, 1);
    vecs[14] = mk(0, 1, 9'h002, 1,  1, 2, 1, 9'h001, 0, 1, 1);
    vecs[15] = mk(0, 1, 9'h003, 1,  1, 2, 1, 9'h002, 0, 1, 1);
    vecs[16] = mk(0, 1, 9'h004, 1,  1, 2, 1, 9'h003, 0, 1, 1);
    vecs[17] = mk(0, 1, 9'h005, 1,  1, 2, 1, 9'h004, 0, 1, 1);
    vecs[18] = mk(0, 1, 9'h006, 1,  1, 2, 1, 9'h005, 0, 1, 1);
    vecs[19] = mk(0, 1, 9'h111, 0,  1, 3, 1, 9'h005, 1, 1, 1);
    vecs[20] = mk(1, 1, 9'h122, 1,  0, 0, 0, 9'h000, 0, 0, 0);
    vecs[21] = mk(0, 1, 9'h0C3, 0,  1, 1, 1, 9'h0C3, 0, 0, 0);
    vecs[22] = mk(0, 1, 9'h0D1, 0,  1, 2, 1, 9'h0C3, 0, 0, 0);

    rst               = 1'b0;
    bus.flush         = 1'b0;
    bus.data_in       = '0;
    bus.data_in_valid = 1'b0;
    bus.data_out_read = 1'b0;

    // Producer already asserting valid while in reset must not be acknowledged.
    #2;
    bus.data_in_valid = 1'b1;
    bus.data_in       = 9'h1C0;
    #1;
    check_output("rst_ack", 32'(bus.data_in_ack), 32'd0);
    check_output("rst_level", 32'(bus.level), 32'd0);
    check_output("rst_valid", 32'(bus.data_out_valid), 32'd0);
    check_output("rst_afull", 32'(bus.almost_full), 32'd0);
    check_output("rst_ovf", 32'(bus.overflow), 32'd0);
    check_output("rst_udf", 32'(bus.underflow), 32'd0);
    @(negedge clk);
    bus.data_in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;

    for (int i = 0; i < 23; i++) apply_stimulus(vecs[i], i);

    // Asynchronous reset mid-burst at level 2, observed before the next rising edge.
    @(negedge clk);
    bus.data_in_valid = 1'b1;
    bus.data_in       = 9'h1E0;
    #2;
    rst = 1'b0;
    #1;
    check_output("async_level", 32'(bus.level), 32'd0);
    check_output("async_valid", 32'(bus.data_out_valid), 32'd0);
    check_output("async_ack", 32'(bus.data_in_ack), 32'd0);
    check_output("async_afull", 32'(bus.almost_full), 32'd0);
    @(posedge clk);
    #1;
    check_output("held_level", 32'(bus.level), 32'd0);
    @(negedge clk);
    bus.data_in_valid = 1'b0;
    rst = 1'b1;

    apply_stimulus(mk(0, 1, 9'h07E, 0,  1, 1, 1, 9'h07E, 0, 0, 0), 100);
    apply_stimulus(mk(0, 1, 9'h1AB, 0,  1, 2, 1, 9'h07E, 0, 0, 0), 101);
    apply_stimulus(mk(0, 0, 9'h000, 1,  0, 1, 1, 9'h1AB, 0, 0, 0), 102);

    @(negedge clk);
    bus.data_out_read = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
